fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 15: maximum cycles to wait for imem_ack before fault.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  word-aligned fetch address (equals PC).
REQ-007 imem_rdata  input  32  instruction word, valid only when imem_ack=1.
REQ-008 imem_ack  input  1  memory response strobe, one cycle per request.
REQ-009 Instr  output  32  held instruction word to controller/datapath.
REQ-010 instr_valid  output  1  Instr is valid and awaiting acceptance.
REQ-011 instr_ready  input  1  consumer accepts Instr this cycle.
REQ-012 PCSrc  input  1  branch/PC-write taken for the instruction being accepted.
REQ-013 PCTarget  input  32  next PC when PCSrc=1.
REQ-014 PC  output  32  address of the currently fetched/held instruction.
REQ-015 PCPlus8  output  32  PC+8 (ARM R15 read value), combinational from PC.
REQ-016 align_err  output  1  one-cycle pulse on misaligned PCTarget redirect.
REQ-017 fetch_fault  output  1  sticky; imem_ack timeout occurred.

Function
REQ-018 FSM states: IDLE, FETCH, HOLD, FAULT.
REQ-019 IDLE: drives no request; transitions unconditionally to FETCH on the next edge.
REQ-020 FETCH: imem_req=1, imem_addr=PC; on imem_ack=1, Instr<=imem_rdata, go to HOLD.
REQ-021 FETCH with imem_ack=1 in the first cycle: instr_valid=1 on the following cycle (one-cycle fetch latency minimum).
REQ-022 HOLD: instr_valid=1, imem_req=0, Instr stable until accepted.
REQ-023 HOLD with instr_ready=1: PC<=PCSrc ? {PCTarget[31:2],2'b00} : PC+4; go to FETCH; instr_valid=0 next cycle.
REQ-024 PCSrc and PCTarget are ignored unless instr_valid=1 and instr_ready=1 in the same cycle.
REQ-025 Redirect with PCTarget[1:0]!=0: low bits forced to 00 and align_err pulses high for exactly that next cycle.
REQ-026 PC+4 arithmetic is modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000 without any flag.
REQ-027 Wait counter: cleared on entry to FETCH, increments each FETCH cycle without ack; saturates at TIMEOUT.
REQ-028 imem_ack on the cycle the counter reaches TIMEOUT is still accepted (ack wins).
REQ-029 Counter at TIMEOUT with no ack: go to FAULT; fetch_fault<=1.
REQ-030 FAULT: imem_req=0, instr_valid=0; remains until reset; PC holds the faulting address.
REQ-031 imem_ack outside FETCH is ignored; Instr and state unchanged.
REQ-032 PCPlus8 = PC+8 modulo 2^32 in every state.

Reset
REQ-033 reset=0 at a rising edge: state<=IDLE, PC<=RESET_PC, Instr<=0, counter<=0, fetch_fault<=0, align_err<=0.
REQ-034 During and directly after reset: imem_req=0, instr_valid=0; first request in the second cycle after reset deasserts.
REQ-035 Reset asserted mid-FETCH or mid-HOLD aborts the operation; a late imem_ack arriving after reset is ignored.
REQ-036 Reset has priority over all other inputs in the same cycle.

Verification
REQ-037 Release reset, ack on first FETCH cycle with rdata=32'hE3A0_1005, ready=1 -> Instr=32'hE3A0_1005, instr_valid for 1 cycle, next imem_addr=32'h4.
REQ-038 HOLD with ready=1, PCSrc=1, PCTarget=32'h0000_0102 -> next imem_addr=32'h0000_0100, align_err=1 for one cycle.
REQ-039 PC=32'hFFFF_FFFC, accept with PCSrc=0 -> next imem_addr=32'h0000_0000, PCPlus8 then 32'h8.
REQ-040 Hold instr_ready=0 for 5 cycles in HOLD, change imem_rdata -> Instr and PC unchanged, no imem_req.
REQ-041 No ack for TIMEOUT cycles -> fetch_fault=1, imem_req=0 thereafter; ack exactly at cycle TIMEOUT -> no fault.
REQ-042 Assert reset mid-FETCH, then ack -> PC=RESET_PC, instr_valid=0, fetch_fault=0, ack ignored.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: requests one word at PC, holds it until the
// consumer accepts it, then advances PC (sequential or redirected).
//
// state | meaning
// IDLE  | post-reset bubble, no request
// FETCH | request outstanding at PC, waiting for imem_ack
// HOLD  | instruction held on Instr, waiting for instr_ready
// FAULT | ack timeout, stuck until reset
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] Instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    output logic [31:0] PC,
    output logic [31:0] PCPlus8,
    output logic        align_err,
    output logic        fetch_fault
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t           state_q;
    logic [31:0]      pc_q;
    logic [31:0]      instr_q;
    logic [CNT_W-1:0] wait_q;
    logic             fault_q;
    logic             align_q;
    logic             req_q;
    logic             valid_q;

    logic [31:0]      next_pc_d;
    logic             misalign_d;

    // Redirect targets are forced word-aligned; the dropped bits raise align_err.
    assign next_pc_d  = PCSrc ? {PCTarget[31:2], 2'b00} : pc_q + 32'd4;
    assign misalign_d = PCSrc && (PCTarget[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            wait_q  <= '0;
            fault_q <= 1'b0;
            align_q <= 1'b0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            align_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                    wait_q  <= '0;
                end
                FETCH: begin
                    // An ack on the final allowed cycle still wins over the timeout.
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        state_q <= HOLD;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end else if (wait_q == TIMEOUT_CNT) begin
                        state_q <= FAULT;
                        req_q   <= 1'b0;
                        fault_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        pc_q    <= next_pc_d;
                        align_q <= misalign_d;
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                        wait_q  <= '0;
                    end
                end
                FAULT: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign Instr       = instr_q;
    assign instr_valid = valid_q;
    assign PC          = pc_q;
    assign PCPlus8     = pc_q + 32'd8;
    assign align_err   = align_q;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// hold/reset/timeout sequences, then random traffic against a reference model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TIMEOUT  = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] Instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic [31:0] PC;
    logic [31:0] PCPlus8;
    logic        align_err;
    logic        fetch_fault;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .Instr       (Instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .PCSrc       (PCSrc),
        .PCTarget    (PCTarget),
        .PC          (PC),
        .PCPlus8     (PCPlus8),
        .align_err   (align_err),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        pcsrc;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic        e_align;
        logic        e_fault;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(logic rst, logic ack, logic [31:0] rdata, logic ready,
                                logic pcsrc, logic [31:0] tgt, logic e_req, logic [31:0] e_addr,
                                logic e_valid, logic [31:0] e_instr, logic e_align, logic e_fault);
        vec_t v;
        v.rst = rst; v.ack = ack; v.rdata = rdata; v.ready = ready;
        v.pcsrc = pcsrc; v.tgt = tgt; v.e_req = e_req; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_instr = e_instr; v.e_align = e_align; v.e_fault = e_fault;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic ack, input logic [31:0] rdata,
                         input logic ready, input logic pcsrc, input logic [31:0] tgt);
        reset       = rst;
        imem_ack    = ack;
        imem_rdata  = rdata;
        instr_ready = ready;
        PCSrc       = pcsrc;
        PCTarget    = tgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic e_valid, input logic [31:0] e_instr,
                           input logic e_align, input logic e_fault);
        chk({tag, ".imem_req"},    32'(imem_req),    32'(e_req));
        chk({tag, ".imem_addr"},   imem_addr,        e_addr);
        chk({tag, ".PC"},          PC,               e_addr);
        chk({tag, ".PCPlus8"},     PCPlus8,          e_addr + 32'd8);
        chk({tag, ".instr_valid"}, 32'(instr_valid), 32'(e_valid));
        chk({tag, ".Instr"},       Instr,            e_instr);
        chk({tag, ".align_err"},   32'(align_err),   32'(e_align));
        chk({tag, ".fetch_fault"}, 32'(fetch_fault), 32'(e_fault));
    endtask

    // Reference model: phases 0=bubble 1=waiting for ack 2=holding 3=dead.
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    int          m_waited;
    logic        m_fault;
    logic        m_align;

    task automatic model_edge();
        if (!reset) begin
            m_phase = 0; m_pc = RESET_PC; m_instr = 0; m_waited = 0;
            m_fault = 0; m_align = 0;
            return;
        end
        m_align = 0;
        if (m_phase == 0) begin
            m_phase  = 1;
            m_waited = 0;
        end else if (m_phase == 1) begin
            if (imem_ack) begin
                m_instr = imem_rdata;
                m_phase = 2;
            end else if (m_waited >= TIMEOUT) begin
                m_phase = 3;
                m_fault = 1;
            end else begin
                m_waited++;
            end
        end else if (m_phase == 2 && instr_ready) begin
            m_align  = PCSrc && (PCTarget % 4 != 0);
            m_pc     = PCSrc ? PCTarget - (PCTarget % 4) : m_pc + 4;
            m_phase  = 1;
            m_waited = 0;
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);

        vecs[0]  = mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 0);
        vecs[1]  = mk(1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         0, 0);
        vecs[2]  = mk(1, 1, 32'hE3A0_1005, 0, 0, 32'h0,         0, 32'h0,         1, 32'hE3A0_1005, 0, 0);
        vecs[3]  = mk(1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h4,         0, 32'hE3A0_1005, 0, 0);
        vecs[4]  = mk(1, 1, 32'h1111_1111, 0, 0, 32'h0,         0, 32'h4,         1, 32'h1111_1111, 0, 0);
        vecs[5]  = mk(1, 0, 32'h0,         1, 1, 32'h0000_0102, 1, 32'h0000_0100, 0, 32'h1111_1111, 1, 0);
        vecs[6]  = mk(1, 0, 32'h0,         1, 1, 32'h0000_0888, 1, 32'h0000_0100, 0, 32'h1111_1111, 0, 0);
        vecs[7]  = mk(1, 1, 32'h2222_2222, 0, 0, 32'h0,         0, 32'h0000_0100, 1, 32'h2222_2222, 0, 0);
        vecs[8]  = mk(1, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h2222_2222, 0, 0);
        vecs[9]  = mk(1, 1, 32'h3333_3333, 0, 0, 32'h0,         0, 32'hFFFF_FFFC, 1, 32'h3333_3333, 0, 0);
        vecs[10] = mk(1, 1, 32'h4444_4444, 0, 1, 32'h0000_0040, 0, 32'hFFFF_FFFC, 1, 32'h3333_3333, 0, 0);
        vecs[11] = mk(1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0000_0000, 0, 32'h3333_3333, 0, 0);

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].rst, vecs[i].ack, vecs[i].rdata, vecs[i].ready, vecs[i].pcsrc, vecs[i].tgt);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                    vecs[i].e_instr, vecs[i].e_align, vecs[i].e_fault);
        end

        // Stall in HOLD: rdata/ack wiggle must not disturb the held word.
        drive(1, 1, 32'h5555_AAAA, 0, 0, 0);
        tick();
        chk_all("hold_enter", 0, 32'h0, 1, 32'h5555_AAAA, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 1'($urandom_range(0, 1)), $urandom, 0, 1, $urandom);
            tick();
            chk_all($sformatf("stall%0d", i), 0, 32'h0, 1, 32'h5555_AAAA, 0, 0);
        end
        drive(1, 0, 0, 1, 0, 0);
        tick();
        chk_all("stall_release", 1, 32'h4, 0, 32'h5555_AAAA, 0, 0);

        // Reset during FETCH, with an ack in the same and following cycle.
        drive(0, 1, 32'h6666_6666, 1, 1, 32'h0000_0200);
        tick();
        chk_all("rst_midfetch", 0, RESET_PC, 0, 32'h0, 0, 0);
        drive(1, 1, 32'h7777_7777, 0, 0, 0);
        tick();
        chk_all("rst_late_ack", 1, RESET_PC, 0, 32'h0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        tick();
        chk_all("rst_still_fetch", 1, RESET_PC, 0, 32'h0, 0, 0);

        // Timeout: TIMEOUT+1 FETCH cycles without ack faults.
        drive(0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        tick();
        for (int i = 1; i <= TIMEOUT; i++) tick();
        chk_all("to_last_wait", 1, RESET_PC, 0, 32'h0, 0, 0);
        tick();
        chk_all("to_fault", 0, RESET_PC, 0, 32'h0, 0, 1);
        drive(1, 1, 32'h8888_8888, 1, 1, 32'h0000_0300);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all($sformatf("fault_sticky%0d", i), 0, RESET_PC, 0, 32'h0, 0, 1);
        end

        // Ack exactly on the last allowed cycle: no fault.
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk_all("to2_reset", 0, RESET_PC, 0, 32'h0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        tick();
        for (int i = 1; i <= TIMEOUT; i++) tick();
        drive(1, 1, 32'h9999_0001, 0, 0, 0);
        tick();
        chk_all("ack_at_timeout", 0, RESET_PC, 1, 32'h9999_0001, 0, 0);

        // Random traffic against the model; ack density varies to hit timeouts.
        for (int i = 0; i < 800; i++) begin
            int ack_pct;
            ack_pct = ((i / 100) % 2 == 0) ? 50 : 8;
            drive((i == 0) ? 1'b0 : 1'($urandom_range(0, 99) >= 3),
                  1'($urandom_range(0, 99) < ack_pct),
                  $urandom,
                  1'($urandom_range(0, 99) < 60),
                  1'($urandom_range(0, 99) < 40),
                  ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom);
            model_edge();
            tick();
            chk_all($sformatf("rnd%0d", i), m_phase == 1, m_pc, m_phase == 2,
                    m_instr, m_align, m_fault);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
